// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   BYTE_W      - width of one transmitted byte
//   arb_state_e - IDLE / WAIT_BUSY / WAIT_DONE
//   id_width()  - width of a requester index for n requesters
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between NUM_REQ byte producers, the arbiter and the downstream uart_tx.
// Signals:
//   req_valid/req_data/req_last - per-requester byte offer (data packed 8 bits per requester)
//   req_ready                   - one-hot accept pulse back to the requester
//   sdata/tx_start              - byte and start pulse into uart_tx
//   tx_busy                     - frame-in-progress flag from uart_tx
// Modports: slave = arbiter, master = environment (requesters plus uart_tx).
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic [BYTE_W-1:0]              sdata;
    logic                           tx_start;
    logic                           tx_busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, sdata, tx_start
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, sdata, tx_start
    );
endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   valid - requesters with a byte pending
//   ptr   - last winner; the scan starts at ptr+1 and wraps modulo NUM_REQ
//   mask  - requesters allowed to win (all ones when no lock is held)
//   found - at least one eligible requester
//   win   - index of the winner (holds ptr when nothing is found)
module uart_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [IDW-1:0]     win
);
    logic [NUM_REQ-1:0] cand;
    logic [IDW-1:0]     sel;

    assign cand = valid & mask;

    always_comb begin
        found = 1'b0;
        win   = ptr;
        sel   = '0;
        // k = NUM_REQ revisits ptr itself, so the last winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && cand[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   bus         - uart_tx_arbiter_if.slave (requester handshake + uart_tx side)
//   grant_id    - index of the last-granted requester
//   arb_busy    - high whenever the FSM is not in IDLE
//   timeout_err - one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT cycles
// Optional feature: define UART_ARB_LOCK_EN to keep the grant on one requester
// until it sends a byte with req_last=1; otherwise req_last is ignored.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    uart_tx_arbiter_if.slave              bus,
    output logic [id_width(NUM_REQ)-1:0]  grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);
    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = $clog2(BUSY_TIMEOUT);

    arb_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // The round-robin pointer and grant_id always hold the same value: the last winner.
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [BYTE_W-1:0]  sdata_q, sdata_d;
    logic               tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               arb_busy_q, arb_busy_d;
    logic               timeout_q, timeout_d;
    logic [NUM_REQ-1:0] lock_mask;
    logic               found;
    logic [IDW-1:0]     win;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    // While locked only the last winner (ptr_q) may be granted, even if it is momentarily idle.
    assign lock_mask = lock_q ? (NUM_REQ'(1) << ptr_q) : '1;
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign lock_mask   = '1;
`endif

    uart_arb_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .mask  (lock_mask),
        .found (found),
        .win   (win)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        sdata_d     = sdata_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        timeout_d   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && found) begin
                    sdata_d     = bus.req_data[win];
                    tx_start_d  = 1'b1;
                    req_ready_d = NUM_REQ'(1) << win;
                    ptr_d       = win;
                    cnt_d       = '0;
                    state_d     = WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
                    // Sets on a non-last byte, clears on the packet's last byte.
                    lock_d      = !bus.req_last[win];
`endif
                end
            end
            WAIT_BUSY: begin
                // Busy wins over the watchdog on the final count.
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NUM_REQ - 1);
            sdata_q     <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            arb_busy_q  <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            sdata_q     <= sdata_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            arb_busy_q  <= arb_busy_d;
            timeout_q   <= timeout_d;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign bus.sdata     = sdata_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.req_ready = req_ready_q;
    assign grant_id      = ptr_q;
    assign arb_busy      = arb_busy_q;
    assign timeout_err   = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and drives `sdata` and `tx_start` into `uart_tx`. It tracks `tx_busy` to sequence each frame to completion before the next grant. It sits directly upstream of `uart_tx`; its `tx_start`, `sdata` and `tx_busy` ports connect one-to-one to it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BUSY_TIMEOUT`, 16: maximum cycles to wait for `tx_busy` to rise after `tx_start`. Must be at least 2.
- `clk` in 1: the single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in NUM_REQ*8: byte of requester i in bits [8i+7:8i].
- `req_last` in NUM_REQ: byte of requester i ends a packet. Used only with lock enabled.
- `req_ready` out NUM_REQ: one-hot, one-cycle pulse. Requester i's byte was taken.
- `sdata` out 8: byte to `uart_tx`.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_busy` in 1: busy flag from `uart_tx`.
- `grant_id` out $clog2(NUM_REQ): index of the last-granted requester.
- `arb_busy` out 1: the block is not in `IDLE`.
- `timeout_err` out 1: one-cycle pulse when the `BUSY_TIMEOUT` watchdog fires.

## Operation
- All outputs are registered. Reset values:
  - `sdata`=0, `tx_start`=0, `req_ready`=0, `grant_id`=NUM_REQ-1, `arb_busy`=0, `timeout_err`=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - State = `IDLE`, lock = 0.
- `IDLE`: when any `req_valid` is high and `tx_busy`=0, pick the winner w.
  - w is the first valid index scanning ptr+1, ptr+2, … and wrapping modulo NUM_REQ.
  - On that edge, register `sdata`=req_data[w], `tx_start`=1, `req_ready`=1<<w, `grant_id`=w, ptr=w.
  - Next state is `WAIT_BUSY`.
  - If `tx_busy`=1 in `IDLE`, the block grants nothing and waits.
- `WAIT_BUSY`: `tx_start` and `req_ready` return to 0 after one cycle. Watchdog counter starts at 0.
  - `tx_busy`=1 goes to `WAIT_DONE`.
  - If the counter reaches BUSY_TIMEOUT-1, pulse `timeout_err` and go to `IDLE`. The byte is dropped; the requester has already been acked.
- `WAIT_DONE`: `tx_busy`=0 goes to `IDLE`. There is no timeout in this state.
- `sdata` holds its value until the next grant.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready`. The arbiter samples data only on the grant edge.
- A requester that drops `req_valid` before it is granted loses its slot silently.
- If all `req_valid` are low, there is no grant and the pointer is unchanged.
- If reset is asserted mid-frame, every register returns to its reset value immediately. The `uart_tx` frame in flight is not the arbiter's concern. After reset, the arbiter waits in `IDLE` until `tx_busy`=0.

## Timing
- Grant latency: `req_valid` high in cycle N with the block in `IDLE` and `tx_busy` low gives `tx_start`, `req_ready` and `sdata` valid in cycle N+1.
- Minimum spacing between `tx_start` pulses is the frame duration plus 2 cycles: `tx_busy` falls, then one cycle in `IDLE`, then the next start.
- Back-to-back requests from every requester are served in strict rotation 0, 1, …, NUM_REQ-1, 0.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - A grant to w with req_last[w]=0 sets the lock.
  - While the lock is set, `IDLE` considers only requester w. All others wait even if w is momentarily idle.
  - A byte accepted from w with req_last[w]=1 clears the lock.
  - Reset clears the lock.
- Not defined: the `req_last` port exists but is ignored, and every grant is pure round-robin.

## Structure
- Package `uart_arb_pkg`:
  - State enum `IDLE`/`WAIT_BUSY`/`WAIT_DONE`.
  - Byte width constant (8).
  - Function computing the `grant_id` width.
- Sub-module `uart_arb_rr_pick`: combinational. Inputs are the valid mask, pointer and optional lock mask; outputs are a found flag and the winner index.
- The top level holds the FSM, watchdog and output registers.

## Test plan
- Reset: hold `rstn`=0 asynchronously mid-cycle → all outputs at reset values at once.
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5 → `tx_start` and `req_ready`=0001 one cycle later with `sdata`=A5. No second start until `tx_busy` rises then falls.
- Contention: all four valid and held continuously → grants in order 0,1,2,3,0 and `grant_id` follows.
- Busy hold-off: `tx_busy`=1 while in `IDLE` with valid=0010 → no `tx_start` until `tx_busy`=0, then a grant the next cycle.
- Watchdog: `tx_busy` held 0 after `tx_start` → `timeout_err` pulses exactly BUSY_TIMEOUT cycles later and the block returns to `IDLE`.
- Lock (`UART_ARB_LOCK_EN`): requester 1 sends three bytes with last=0,0,1 while requester 2 is valid → requester 2 is granted only after the third byte.
